// File: rtl/text_line_display_if.sv
// Load bus for text_line_display: glyph codes and colour with a ready/load handshake.
interface text_line_display_if #(
    parameter int NUM_CHARS = 4
);
    logic [6*NUM_CHARS-1:0] chars;
    logic [23:0]            color;
    logic                   load;
    logic                   ready;

    modport master (output chars, color, load, input ready);
    modport slave  (input chars, color, load, output ready);
endinterface

// File: rtl/text_line_display.sv
// One-line text overlay: double-buffered glyph codes, blink gating, and a
// 3-stage raster pipeline around an external synchronous glyph ROM.
module text_line_display #(
    parameter int NUM_CHARS    = 4,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    text_line_display_if.slave ld,
    input  logic               frame_start,
    input  logic               blink_en,
    input  logic [10:0]        origin_x,
    input  logic [9:0]         origin_y,
    input  logic [10:0]        vga_x,
    input  logic [9:0]         vga_y,
    input  logic               valid,
    output logic [8:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic               valid_px
);
    localparam int         CELL   = 8 << SCALE_LOG2;
    localparam logic [11:0] LINE_W = 12'(NUM_CHARS * CELL);
    localparam logic [10:0] LINE_H = 11'(CELL);

    typedef enum logic {IDLE, PENDING} state_t;

    typedef struct packed {
        logic [6*NUM_CHARS-1:0] chars;
        logic [23:0]            color;
    } buf_t;

    state_t     state;
    buf_t       pend;
    buf_t       act;
    logic       ready_q;
    logic       display_on;
    logic [7:0] frame_cnt;
    logic       blink_phase;

    assign ld.ready = ready_q;

    // Control: load handshake, commit on frame boundary, blink frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            pend        <= '0;
            act         <= '0;
            display_on  <= 1'b0;
            frame_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld.load) begin
                        pend.chars <= ld.chars;
                        pend.color <= ld.color;
                        state      <= PENDING;
                        ready_q    <= 1'b0;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        act        <= pend;
                        display_on <= 1'b1;
                        state      <= IDLE;
                        ready_q    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (frame_start) begin
                if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= 8'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // Zero-extended subtraction: the top bit flags raster left of / above origin.
    logic [11:0] dx;
    logic [10:0] dy;
    logic [11:0] slot;
    logic [2:0]  col;
    logic [2:0]  row;
    logic        hit;
    logic        gate;
    logic [5:0]  slot_code;

    assign dx   = {1'b0, vga_x} - {1'b0, origin_x};
    assign dy   = {1'b0, vga_y} - {1'b0, origin_y};
    assign hit  = valid && !dx[11] && !dy[10] && (dx < LINE_W) && (dy < LINE_H);
    assign slot = dx >> (3 + SCALE_LOG2);
    assign col  = 3'(dx >> SCALE_LOG2);
    assign row  = 3'(dy >> SCALE_LOG2);
    assign gate = display_on & ~(blink_en & blink_phase);

    always_comb begin
        slot_code = '0;
        for (int k = 0; k < NUM_CHARS; k++) begin
            if (slot == 12'(k)) slot_code = act.chars[6*k +: 6];
        end
    end

    localparam int STAGES = 2;

    logic [STAGES-1:0]       vld_pipe;
    logic [STAGES-1:0][2:0]  col_pipe;
    logic                    px_on;

    // rom_data bit 7 is the leftmost column, so the bit index is ~col.
    assign px_on = vld_pipe[STAGES-1] & rom_data[~col_pipe[STAGES-1]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr  <= '0;
            vld_pipe  <= '0;
            col_pipe  <= '0;
            valid_px  <= 1'b0;
            {r, g, b} <= 24'h0;
        end else begin
            rom_addr  <= {slot_code, row};
            vld_pipe  <= {vld_pipe[STAGES-2:0], hit & gate};
            col_pipe  <= {col_pipe[STAGES-2:0], col};
            valid_px  <= px_on;
            {r, g, b} <= px_on ? act.color : 24'h0;
        end
    end
endmodule
